// File: rtl/parking_gate_if.sv
// Lane-side bundle for the parking gate scheduler: debounced requests and loop
// sensor in, grant/deny, gate drive, space counts and lamps out.
interface parking_gate_if #(
  parameter int CNT_W = 8
) ();
  logic             req_ent_reg;
  logic             req_ent_hc;
  logic             req_ext_reg;
  logic             req_ext_hc;
  logic             car_passed;
  logic [3:0]       grant;
  logic [3:0]       deny;
  logic             gate_open;
  logic             gate_closing;
  logic [CNT_W-1:0] free_reg;
  logic [CNT_W-1:0] free_hc;
  logic             reg_green;
  logic             reg_red;
  logic             hc_green;
  logic             hc_red;
  logic             timeout;

  modport master (
    output req_ent_reg, req_ent_hc, req_ext_reg, req_ext_hc, car_passed,
    input  grant, deny, gate_open, gate_closing, free_reg, free_hc,
           reg_green, reg_red, hc_green, hc_red, timeout
  );

  modport slave (
    input  req_ent_reg, req_ent_hc, req_ext_reg, req_ext_hc, car_passed,
    output grant, deny, gate_open, gate_closing, free_reg, free_hc,
           reg_green, reg_red, hc_green, hc_red, timeout
  );
endinterface

// File: rtl/parking_gate_scheduler.sv
// Arbitrates four lane requests onto one barrier gate and keeps free-space
// counts for regular and handicap classes; one car transaction at a time.
module parking_gate_scheduler #(
  parameter int REG_SPACES   = 20,
  parameter int HC_SPACES    = 5,
  parameter int CNT_W        = 8,
  parameter int OPEN_CYC     = 4,
  parameter int PASS_TIMEOUT = 1000,
  parameter int CLOSE_CYC    = 4,
  parameter int TMR_W        = 16,
  parameter bit SPILL_EN     = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  parking_gate_if.slave  bus
);
  localparam logic [CNT_W-1:0] REG_CAP    = CNT_W'(REG_SPACES);
  localparam logic [CNT_W-1:0] HC_CAP     = CNT_W'(HC_SPACES);
  localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_CYC - 1);
  localparam logic [TMR_W-1:0] PASS_LAST  = TMR_W'(PASS_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(CLOSE_CYC - 1);

  typedef enum logic [1:0] {IDLE, OPENING, WAIT_PASS, CLOSING} state_t;

  state_t           state_reg;
  logic [TMR_W-1:0] timer_reg;
  logic [CNT_W-1:0] free_reg_reg;
  logic [CNT_W-1:0] free_hc_reg;
  logic             rr_hc_reg;      // 1: handicap entry has round-robin priority
  logic             txn_hc_reg;     // class charged for the transaction in flight
  logic             txn_exit_reg;
  logic [3:0]       grant_reg;
  logic [3:0]       deny_reg;
  logic             timeout_reg;
  logic             gate_open_reg;
  logic             gate_closing_reg;

  logic [3:0] pick;
  logic       pick_ok;
  logic       pick_hc;
  logic       pick_exit;

  // Single winner per IDLE cycle; a handicap entry that spills is charged to regular.
  always_comb begin
    pick      = 4'b0000;
    pick_ok   = 1'b0;
    pick_hc   = 1'b0;
    pick_exit = 1'b0;
    if (bus.req_ext_hc) begin
      pick      = 4'b1000;
      pick_exit = 1'b1;
      pick_hc   = 1'b1;
      pick_ok   = (free_hc_reg < HC_CAP);
    end else if (bus.req_ext_reg) begin
      pick      = 4'b0100;
      pick_exit = 1'b1;
      pick_ok   = (free_reg_reg < REG_CAP);
    end else if (bus.req_ent_hc && (rr_hc_reg || !bus.req_ent_reg)) begin
      pick = 4'b0010;
      if (free_hc_reg != '0) begin
        pick_ok = 1'b1;
        pick_hc = 1'b1;
      end else if (SPILL_EN && (free_reg_reg != '0)) begin
        pick_ok = 1'b1;
      end
    end else if (bus.req_ent_reg) begin
      pick    = 4'b0001;
      pick_ok = (free_reg_reg != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      timer_reg        <= '0;
      free_reg_reg     <= REG_CAP;
      free_hc_reg      <= HC_CAP;
      rr_hc_reg        <= 1'b0;
      txn_hc_reg       <= 1'b0;
      txn_exit_reg     <= 1'b0;
      grant_reg        <= 4'b0000;
      deny_reg         <= 4'b0000;
      timeout_reg      <= 1'b0;
      gate_open_reg    <= 1'b0;
      gate_closing_reg <= 1'b0;
    end else begin
      grant_reg   <= 4'b0000;
      deny_reg    <= 4'b0000;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick != 4'b0000) begin
            if (pick_ok) begin
              grant_reg     <= pick;
              txn_hc_reg    <= pick_hc;
              txn_exit_reg  <= pick_exit;
              gate_open_reg <= 1'b1;
              timer_reg     <= '0;
              state_reg     <= OPENING;
              if (!pick_exit) rr_hc_reg <= pick[0];
            end else begin
              deny_reg <= pick;
            end
          end
        end
        OPENING: begin
          if (timer_reg == OPEN_LAST) begin
            timer_reg <= '0;
            state_reg <= WAIT_PASS;
          end else begin
            timer_reg <= timer_reg + TMR_W'(1);
          end
        end
        WAIT_PASS: begin
          if (bus.car_passed || (timer_reg == PASS_LAST)) begin
            timer_reg        <= '0;
            gate_open_reg    <= 1'b0;
            gate_closing_reg <= 1'b1;
            state_reg        <= CLOSING;
            if (!bus.car_passed) begin
              timeout_reg <= 1'b1;
            end else if (txn_exit_reg) begin
              if (txn_hc_reg && (free_hc_reg < HC_CAP))
                free_hc_reg <= free_hc_reg + CNT_W'(1);
              else if (!txn_hc_reg && (free_reg_reg < REG_CAP))
                free_reg_reg <= free_reg_reg + CNT_W'(1);
            end else begin
              if (txn_hc_reg && (free_hc_reg != '0))
                free_hc_reg <= free_hc_reg - CNT_W'(1);
              else if (!txn_hc_reg && (free_reg_reg != '0))
                free_reg_reg <= free_reg_reg - CNT_W'(1);
            end
          end else begin
            timer_reg <= timer_reg + TMR_W'(1);
          end
        end
        CLOSING: begin
          if (timer_reg == CLOSE_LAST) begin
            gate_closing_reg <= 1'b0;
            state_reg        <= IDLE;
          end else begin
            timer_reg <= timer_reg + TMR_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.grant        = grant_reg;
  assign bus.deny         = deny_reg;
  assign bus.gate_open    = gate_open_reg;
  assign bus.gate_closing = gate_closing_reg;
  assign bus.timeout      = timeout_reg;
  assign bus.free_reg     = free_reg_reg;
  assign bus.free_hc      = free_hc_reg;
  assign bus.reg_green    = (free_reg_reg != '0);
  assign bus.reg_red      = (free_reg_reg == '0);
  assign bus.hc_green     = (free_hc_reg != '0);
  assign bus.hc_red       = (free_hc_reg == '0);
endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed bench for parking_gate_scheduler: entries, spill, arbitration,
// deny, timeout and mid-transaction reset with hand-computed expectations.
module tb_parking_gate_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_vec = 4'b0000;   // {ext_hc, ext_reg, ent_hc, ent_reg}
  logic       car = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  parking_gate_if #(.CNT_W(8)) bus ();

  assign bus.req_ent_reg = req_vec[0];
  assign bus.req_ent_hc  = req_vec[1];
  assign bus.req_ext_reg = req_vec[2];
  assign bus.req_ext_hc  = req_vec[3];
  assign bus.car_passed  = car;

  parking_gate_scheduler #(
    .REG_SPACES(20), .HC_SPACES(5), .CNT_W(8), .OPEN_CYC(4),
    .PASS_TIMEOUT(1000), .CLOSE_CYC(4), .TMR_W(16), .SPILL_EN(1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transaction with the car passing two cycles after OPENING ends.
  task automatic txn(input logic [3:0] exp_grant, input string name);
    tick();
    chk({name, " grant"}, 16'(bus.grant), 16'(exp_grant));
    chk({name, " open"}, 16'(bus.gate_open), 16'd1);
    req_vec = req_vec & ~exp_grant;
    repeat (4) tick();
    chk({name, " wait open"}, 16'(bus.gate_open), 16'd1);
    chk({name, " wait closing"}, 16'(bus.gate_closing), 16'd0);
    tick();
    car = 1'b1;
    tick();
    car = 1'b0;
    chk({name, " closing"}, 16'(bus.gate_closing), 16'd1);
    chk({name, " open off"}, 16'(bus.gate_open), 16'd0);
    chk({name, " no timeout"}, 16'(bus.timeout), 16'd0);
    repeat (3) tick();
    chk({name, " closing held"}, 16'(bus.gate_closing), 16'd1);
    tick();
    chk({name, " idle"}, 16'(bus.gate_closing), 16'd0);
    $display("txn %s grant=%b free_reg=%0d free_hc=%0d", name, exp_grant, bus.free_reg, bus.free_hc);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    chk("rst free_reg", 16'(bus.free_reg), 16'd20);
    chk("rst free_hc", 16'(bus.free_hc), 16'd5);
    chk("rst reg_green", 16'(bus.reg_green), 16'd1);
    chk("rst reg_red", 16'(bus.reg_red), 16'd0);
    chk("rst hc_green", 16'(bus.hc_green), 16'd1);
    chk("rst gate_open", 16'(bus.gate_open), 16'd0);
    chk("rst gate_closing", 16'(bus.gate_closing), 16'd0);
    chk("rst grant", 16'(bus.grant), 16'd0);
    chk("rst deny", 16'(bus.deny), 16'd0);
    chk("rst timeout", 16'(bus.timeout), 16'd0);

    req_vec = 4'b0001;
    txn(4'b0001, "ent_reg");
    chk("ent_reg free_reg", 16'(bus.free_reg), 16'd19);

    req_vec = 4'b1000;
    tick();
    chk("ext_hc deny", 16'(bus.deny), 16'h8);
    chk("ext_hc no grant", 16'(bus.grant), 16'd0);
    chk("ext_hc no gate", 16'(bus.gate_open), 16'd0);
    req_vec = 4'b0000;
    tick();
    chk("deny pulse", 16'(bus.deny), 16'd0);
    chk("deny gate idle", 16'(bus.gate_open), 16'd0);
    $display("txn ext_hc denied");

    for (int i = 0; i < 5; i++) begin
      req_vec = 4'b0010;
      txn(4'b0010, "ent_hc");
      chk("ent_hc free_hc", 16'(bus.free_hc), 16'(4 - i));
    end
    chk("hc_red", 16'(bus.hc_red), 16'd1);
    chk("hc_green", 16'(bus.hc_green), 16'd0);

    req_vec = 4'b0010;
    txn(4'b0010, "spill");
    chk("spill free_reg", 16'(bus.free_reg), 16'd18);
    chk("spill free_hc", 16'(bus.free_hc), 16'd0);

    req_vec = 4'b0111;
    txn(4'b0100, "arb ext_reg");
    chk("arb1 free_reg", 16'(bus.free_reg), 16'd19);
    txn(4'b0001, "arb ent_reg");
    chk("arb2 free_reg", 16'(bus.free_reg), 16'd18);
    txn(4'b0010, "arb ent_hc");
    chk("arb3 free_reg", 16'(bus.free_reg), 16'd17);
    chk("arb3 free_hc", 16'(bus.free_hc), 16'd0);

    req_vec = 4'b1000;
    txn(4'b1000, "ext_hc");
    chk("ext_hc free_hc", 16'(bus.free_hc), 16'd1);
    chk("ext_hc hc_green", 16'(bus.hc_green), 16'd1);

    // No car: car_passed during OPENING must be ignored, then timeout.
    req_vec = 4'b0001;
    tick();
    chk("to grant", 16'(bus.grant), 16'd1);
    req_vec = 4'b0000;
    tick();
    car = 1'b1;
    tick();
    car = 1'b0;
    repeat (2) tick();
    chk("to wait open", 16'(bus.gate_open), 16'd1);
    repeat (999) tick();
    chk("to before", 16'(bus.timeout), 16'd0);
    chk("to still open", 16'(bus.gate_open), 16'd1);
    tick();
    chk("to pulse", 16'(bus.timeout), 16'd1);
    chk("to closing", 16'(bus.gate_closing), 16'd1);
    chk("to open off", 16'(bus.gate_open), 16'd0);
    tick();
    chk("to pulse end", 16'(bus.timeout), 16'd0);
    chk("to free_reg", 16'(bus.free_reg), 16'd17);
    chk("to free_hc", 16'(bus.free_hc), 16'd1);
    repeat (3) tick();
    chk("to idle", 16'(bus.gate_closing), 16'd0);
    $display("txn timeout free_reg=%0d free_hc=%0d", bus.free_reg, bus.free_hc);

    req_vec = 4'b0001;
    tick();
    chk("rw grant", 16'(bus.grant), 16'd1);
    req_vec = 4'b0000;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw gate_open", 16'(bus.gate_open), 16'd0);
    chk("rw free_reg", 16'(bus.free_reg), 16'd20);
    chk("rw free_hc", 16'(bus.free_hc), 16'd5);
    $display("txn reset in WAIT_PASS");

    req_vec = 4'b0100;
    tick();
    chk("ext_reg deny", 16'(bus.deny), 16'h4);
    chk("ext_reg no gate", 16'(bus.gate_open), 16'd0);
    req_vec = 4'b0000;
    tick();
    $display("txn ext_reg denied");

    req_vec = 4'b0011;
    txn(4'b0001, "rr reset ptr");
    txn(4'b0010, "rr ent_hc");
    chk("rr free_reg", 16'(bus.free_reg), 16'd19);
    chk("rr free_hc", 16'(bus.free_hc), 16'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
